gearbox_downsizing_2x: RTL and testbench
========================================

// Module: gearbox_downsizing_2x
// PURPOSE
//  AXI-Stream width halver: accepts one 2*nb-bit word and emits it as two nb-bit beats.
//  Inverse of the 2x upsizer; first emitted beat = upper half in_tdata[2nb-1:nb], second = lower half.
//  upsizer->downsizer loopback is therefore data-transparent.
//  Sits between wide datapath stages and narrow links/FIFOs; registered output, one-word holding buffer.
// PARAMETERS
//  n   5      bytes per narrow beat
//  nb  n*8    narrow beat width in bits; input width is 2*nb
// PORTS
//  aclk        in   1      clock, all logic on rising edge
//  areset      in   1      asynchronous, active-high reset
//  in_tdata    in   2*nb   wide input word
//  in_tlast    in   1      packet end marker for the wide word
//  in_tvalid   in   1      input valid
//  in_tready   out  1      input ready
//  in_tkeep_hi in   1      only with GBX_DOWN_PARTIAL_EN: 1 = upper half carries data
//  out_tdata   out  nb     narrow output beat (registered)
//  out_tlast   out  1      packet end on narrow side (registered)
//  out_tvalid  out  1      output valid (registered)
//  out_tready  in   1      output ready
// BEHAVIOUR
//  - One clock (aclk); reset areset is asynchronous, active-high.
//  - Reset values: state=EMPTY, out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=1 (comb, from state).
//  - States:
//    - EMPTY: no word held.
//    - FIRST: upper half presented.
//    - SECOND: lower half presented.
//  - Word accept = in_tvalid & in_tready.
//    - Captures lower half + in_tlast into hold register.
//    - Loads upper half into out_tdata with out_tlast=0; next state FIRST.
//  - in_tready = (state==EMPTY) | (state==SECOND & out_tready); combinational, no in_tvalid dependency.
//  - FIRST & out_tready: out_tdata<=held lower half, out_tlast<=held tlast; -> SECOND.
//  - SECOND & out_tready:
//    - with accept: load next word, -> FIRST (no bubble);
//    - without accept: out_tvalid<=0, -> EMPTY.
//  - Latency: accept at edge k -> out_tvalid=1 after edge k; lower half one handshake later.
//  - Throughput: one wide word per 2 cycles sustained when out_tready=1.
//  - Backpressure: out_tready=0 freezes out_tdata/out_tlast/out_tvalid and state.
//    AXI rule: output never changes while valid&~ready.
//  - out_tlast is never set on the upper-half beat.
//  - Reset mid-word discards held data; no partial beat emitted after reset release.
// CONFIGURATION
//  - Macro GBX_DOWN_PARTIAL_EN defined:
//    - port in_tkeep_hi exists.
//    - Accept with in_tkeep_hi=0: upper half skipped; out_tdata<=lower half, out_tlast<=in_tlast; -> SECOND.
//    - Word emits exactly one beat.
//  - Undefined: port absent, every word emits two beats.
// STRUCTURE
//  - Package gearbox_pkg: typedef enum logic [1:0] {GBX_EMPTY, GBX_FIRST, GBX_SECOND} gbx_state_t.
//    Shared with future gearbox variants.
//  - Single module, no sub-module: hold register, 3-state FSM, output register.
// TESTING (n=1, nb=8)
//  - Reset: areset=1 mid-FIRST -> out_tvalid=0, in_tready=1 asynchronously; no stale beat after release.
//  - Single word: in 16'hA1B2, tlast=1, out_tready=1
//    -> beats 8'hA1 (tlast 0), 8'hB2 (tlast 1) on consecutive cycles.
//  - Streaming: words 16'h0102, 16'h0304, 16'h0506 back-to-back, out_tready=1
//    -> 01,02,03,04,05,06 with no gaps; in_tready pattern 1,0,1,0,1.
//  - Backpressure: out_tready=0 for 5 cycles while 8'hA1 presented
//    -> out_tdata/out_tvalid stable, in_tready=0; resumes with 8'hB2.
//  - Loopback: random upsizer->downsizer chain, random valid/ready
//    -> output stream equals input stream bit-exactly.
//  - GBX_DOWN_PARTIAL_EN: 16'hFF33, tkeep_hi=0, tlast=1
//    -> single beat 8'h33 tlast=1; next word starts FIRST immediately.

Source files
------------

// File: rtl/gearbox_pkg.sv
// ============================================================================
// Module      : gearbox_pkg
// Description : Shared types for the gearbox family (state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gearbox_pkg;

  typedef enum logic [1:0] {
    GBX_EMPTY  = 2'd0,
    GBX_FIRST  = 2'd1,
    GBX_SECOND = 2'd2
  } gbx_state_t;

endpackage : gearbox_pkg

`default_nettype wire

// File: rtl/gearbox_downsizing_2x.sv
// ============================================================================
// Module      : gearbox_downsizing_2x
// Description : AXI-Stream 2:1 width halver; upper half is emitted first.
//               Optional macro GBX_DOWN_PARTIAL_EN adds in_tkeep_hi so a word
//               may carry only its lower half (single output beat).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gearbox_downsizing_2x
  import gearbox_pkg::*;
#(
  parameter int N  = 5,
  parameter int NB = N * 8
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [2*NB-1:0] in_tdata,
  input  logic            in_tlast,
  input  logic            in_tvalid,
  output logic            in_tready,
`ifdef GBX_DOWN_PARTIAL_EN
  input  logic            in_tkeep_hi,
`endif
  output logic [NB-1:0]   out_tdata,
  output logic            out_tlast,
  output logic            out_tvalid,
  input  logic            out_tready
);

  gbx_state_t      state_q, state_d;
  logic [NB-1:0]   hold_q, hold_d;
  logic            hold_last_q, hold_last_d;
  logic [NB-1:0]   odata_q, odata_d;
  logic            olast_q, olast_d;
  logic            ovalid_q, ovalid_d;
  logic            w_accept;

  // Ready only depends on state and downstream ready, never on in_tvalid.
  assign in_tready = (state_q == GBX_EMPTY) || ((state_q == GBX_SECOND) && out_tready);
  assign w_accept  = in_tvalid && in_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= GBX_EMPTY;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      odata_q     <= '0;
      olast_q     <= 1'b0;
      ovalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      odata_q     <= odata_d;
      olast_q     <= olast_d;
      ovalid_q    <= ovalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    odata_d     = odata_q;
    olast_d     = olast_q;
    ovalid_d    = ovalid_q;

    case (state_q)
      GBX_EMPTY: ;
      GBX_FIRST: begin
        if (out_tready) begin
          odata_d = hold_q;
          olast_d = hold_last_q;
          state_d = GBX_SECOND;
        end
      end
      GBX_SECOND: begin
        if (out_tready && !w_accept) begin
          ovalid_d = 1'b0;
          state_d  = GBX_EMPTY;
        end
      end
      default: state_d = GBX_EMPTY;
    endcase

    // A new word can only arrive in EMPTY or in a completing SECOND, so it
    // overrides whatever the case above decided.
    if (w_accept) begin
      hold_d      = in_tdata[NB-1:0];
      hold_last_d = in_tlast;
      odata_d     = in_tdata[2*NB-1:NB];
      olast_d     = 1'b0;
      ovalid_d    = 1'b1;
      state_d     = GBX_FIRST;
`ifdef GBX_DOWN_PARTIAL_EN
      if (!in_tkeep_hi) begin
        odata_d = in_tdata[NB-1:0];
        olast_d = in_tlast;
        state_d = GBX_SECOND;
      end
`endif
    end
  end

  assign out_tdata  = odata_q;
  assign out_tlast  = olast_q;
  assign out_tvalid = ovalid_q;

endmodule : gearbox_downsizing_2x

`default_nettype wire

// File: tb/tb_gearbox_downsizing_2x.sv
// ============================================================================
// Module      : tb_gearbox_downsizing_2x
// Description : Self-checking bench for gearbox_downsizing_2x (N=1, NB=8).
//               Honours GBX_DOWN_PARTIAL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gearbox_downsizing_2x;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] in_tdata;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
`ifdef GBX_DOWN_PARTIAL_EN
  logic        in_tkeep_hi;
`endif
  logic [7:0]  out_tdata;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  gearbox_downsizing_2x #(.N(1), .NB(8)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
`ifdef GBX_DOWN_PARTIAL_EN
    .in_tkeep_hi(in_tkeep_hi),
`endif
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t  vecs[18];
  beat_t expq[$];

  initial begin
    logic       have_word, acc, hs;
    logic [7:0] b0, b1, od;
    logic       ol;
    beat_t      e;

    // single word, streaming, backpressure (inputs; expected in_tready; outputs after edge)
    vecs[0]  = '{1'b1, 16'hA1B2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 16'h0102, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[4]  = '{1'b1, 16'h0304, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, 16'h0304, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
    vecs[6]  = '{1'b1, 16'h0506, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0};
    vecs[7]  = '{1'b1, 16'h0506, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 16'hA1B2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
    for (int i = 11; i < 16; i++)
      vecs[i] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    areset     = 1'b1;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
`ifdef GBX_DOWN_PARTIAL_EN
    in_tkeep_hi = 1'b1;
`endif
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("reset_out_tlast",  32'(out_tlast),  32'd0);
    chk("reset_out_tdata",  32'(out_tdata),  32'd0);
    chk("reset_in_tready",  32'(in_tready),  32'd1);
    #2 areset = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < 18; i++) begin
      in_tvalid  = vecs[i].v;
      in_tdata   = vecs[i].d;
      in_tlast   = vecs[i].l;
      out_tready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_tready", i), 32'(in_tready), 32'(vecs[i].e_ir));
      @(posedge aclk); #1;
      chk($sformatf("vec%0d_out_tvalid", i), 32'(out_tvalid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_tdata", i), 32'(out_tdata), 32'(vecs[i].e_od));
        chk($sformatf("vec%0d_out_tlast", i), 32'(out_tlast), 32'(vecs[i].e_ol));
      end
    end

    // asynchronous reset while the upper half is presented
    in_tvalid  = 1'b1;
    in_tdata   = 16'hC3D4;
    in_tlast   = 1'b1;
    out_tready = 1'b0;
    @(posedge aclk); #1;
    in_tvalid = 1'b0;
    chk("prereset_out_tvalid", 32'(out_tvalid), 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("async_reset_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("async_reset_in_tready",  32'(in_tready),  32'd1);
    chk("async_reset_out_tdata",  32'(out_tdata),  32'd0);
    #1 areset = 1'b0;
    out_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      chk($sformatf("post_reset_no_stale%0d", i), 32'(out_tvalid), 32'd0);
    end

`ifdef GBX_DOWN_PARTIAL_EN
    in_tvalid   = 1'b1;
    in_tdata    = 16'hFF33;
    in_tlast    = 1'b1;
    in_tkeep_hi = 1'b0;
    @(posedge aclk); #1;
    chk("partial_valid", 32'(out_tvalid), 32'd1);
    chk("partial_data",  32'(out_tdata),  32'h33);
    chk("partial_last",  32'(out_tlast),  32'd1);
    in_tdata    = 16'h1122;
    in_tlast    = 1'b0;
    in_tkeep_hi = 1'b1;
    #1;
    chk("partial_next_ready", 32'(in_tready), 32'd1);
    @(posedge aclk); #1;
    in_tvalid = 1'b0;
    chk("partial_next_first", 32'(out_tdata), 32'h11);
    chk("partial_next_first_last", 32'(out_tlast), 32'd0);
    @(posedge aclk); #1;
    chk("partial_next_second", 32'(out_tdata), 32'h22);
    @(posedge aclk); #1;
    chk("partial_idle", 32'(out_tvalid), 32'd0);
`endif

    // randomised chain: narrow bytes paired upsizer-style, then halved again
    have_word = 1'b0;
    in_tvalid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!have_word) begin
        b0        = 8'($urandom);
        b1        = 8'($urandom);
        in_tdata  = {b0, b1};
        in_tlast  = 1'($urandom);
        have_word = 1'b1;
      end
      if (!in_tvalid) in_tvalid = ($urandom_range(0, 3) != 0);
      out_tready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_tvalid && in_tready;
      hs  = out_tvalid && out_tready;
      od  = out_tdata;
      ol  = out_tlast;
      if (acc) begin
        expq.push_back('{d: in_tdata[15:8], l: 1'b0});
        expq.push_back('{d: in_tdata[7:0],  l: in_tlast});
      end
      if (hs) begin
        if (expq.size() == 0) chk("loop_unexpected_beat", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("loop_beat", 32'({od, ol}), 32'({e.d, e.l}));
        end
      end
      @(posedge aclk); #1;
      if (acc) begin
        have_word = 1'b0;
        in_tvalid = 1'b0;
      end
    end
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_tvalid) begin
        if (expq.size() == 0) chk("drain_unexpected_beat", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("drain_beat", 32'({out_tdata, out_tlast}), 32'({e.d, e.l}));
        end
      end
      @(posedge aclk); #1;
    end
    chk("loop_all_beats_out", 32'(expq.size()), 32'd0);
    chk("loop_idle", 32'(out_tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gearbox_downsizing_2x

`default_nettype wire
